// File: rtl/sc_level_timer.sv
// Level pacing timer: emits a one-cycle TICK every P(LEVEL) cycles, advances LEVEL
// every TICKS_PER_LEVEL ticks and holds in DONE after the final level's last tick.
module sc_level_timer #(
    parameter int unsigned CNT_WIDTH       = 25,
    parameter int unsigned LV_WIDTH        = 8,
    parameter int unsigned PERIOD_SLOW     = 17500000,
    parameter int unsigned PERIOD_MED      = 15000000,
    parameter int unsigned PERIOD_FAST     = 12500000,
    parameter int unsigned LV_SLOW_MAX     = 10,
    parameter int unsigned LV_MED_MAX      = 32,
    parameter int unsigned LV_MAX          = 59,
    parameter int unsigned TICKS_PER_LEVEL = 16
) (
    input  logic                SC_LEVELTIMER_CLOCK_50,
    input  logic                SC_LEVELTIMER_RESET_InLow,
    input  logic                SC_LEVELTIMER_START_InLow,
    input  logic                SC_LEVELTIMER_PAUSE_InHigh,
    input  logic                SC_LEVELTIMER_CLEAR_InHigh,
    output logic                SC_LEVELTIMER_TICK_Out,
    output logic [LV_WIDTH-1:0] SC_LEVELTIMER_LEVEL_Out,
    output logic [1:0]          SC_LEVELTIMER_SPEEDSEL_Out,
    output logic                SC_LEVELTIMER_RUNNING_Out,
    output logic                SC_LEVELTIMER_DONE_Out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned TC_WIDTH = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    // The counter holds "edges left before the tick", so a period of P reloads P-1.
    localparam logic [CNT_WIDTH-1:0] RELOAD_SLOW = CNT_WIDTH'(PERIOD_SLOW - 1);
    localparam logic [CNT_WIDTH-1:0] RELOAD_MED  = CNT_WIDTH'(PERIOD_MED - 1);
    localparam logic [CNT_WIDTH-1:0] RELOAD_FAST = CNT_WIDTH'(PERIOD_FAST - 1);
    localparam logic [LV_WIDTH-1:0]  LV_SLOW_TOP = LV_WIDTH'(LV_SLOW_MAX);
    localparam logic [LV_WIDTH-1:0]  LV_MED_TOP  = LV_WIDTH'(LV_MED_MAX);
    localparam logic [LV_WIDTH-1:0]  LV_LAST     = LV_WIDTH'(LV_MAX);
    localparam logic [TC_WIDTH-1:0]  TC_LAST     = TC_WIDTH'(TICKS_PER_LEVEL - 1);

    function automatic logic [1:0] band_of(input logic [LV_WIDTH-1:0] lv);
        if (lv <= LV_SLOW_TOP) begin
            return 2'd0;
        end else if (lv <= LV_MED_TOP) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] reload_for(input logic [LV_WIDTH-1:0] lv);
        case (band_of(lv))
            2'd0:    return RELOAD_SLOW;
            2'd1:    return RELOAD_MED;
            default: return RELOAD_FAST;
        endcase
    endfunction

    state_t                state_reg,    state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg,      cnt_next;
    logic [TC_WIDTH-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [LV_WIDTH-1:0]   level_reg,    level_next;
    logic                  tick_reg,     tick_next;

    always_ff @(posedge SC_LEVELTIMER_CLOCK_50 or negedge SC_LEVELTIMER_RESET_InLow) begin
        if (!SC_LEVELTIMER_RESET_InLow) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            tick_cnt_reg <= '0;
            level_reg    <= '0;
            tick_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            tick_cnt_reg <= tick_cnt_next;
            level_reg    <= level_next;
            tick_reg     <= tick_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        level_next    = level_reg;
        tick_next     = 1'b0;

        if (SC_LEVELTIMER_CLEAR_InHigh) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            tick_cnt_next = '0;
            level_next    = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!SC_LEVELTIMER_START_InLow) begin
                        state_next = ST_RUN;
                        cnt_next   = reload_for(level_reg);
                    end
                end

                // PAUSE is "RUN with the clock gated": the edge on which the pause input
                // drops already counts as a normal running edge.
                ST_RUN, ST_PAUSE: begin
                    if (SC_LEVELTIMER_PAUSE_InHigh) begin
                        state_next = ST_PAUSE;
                    end else begin
                        state_next = ST_RUN;
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_WIDTH'(1);
                        end else begin
                            tick_next = 1'b1;
                            cnt_next  = reload_for(level_reg);
                            if (tick_cnt_reg == TC_LAST) begin
                                tick_cnt_next = '0;
                                if (level_reg < LV_LAST) begin
                                    level_next = level_reg + LV_WIDTH'(1);
                                    cnt_next   = reload_for(level_reg + LV_WIDTH'(1));
                                end else begin
                                    state_next = ST_DONE;
                                end
                            end else begin
                                tick_cnt_next = tick_cnt_reg + TC_WIDTH'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_next = ST_DONE;
                end
            endcase
        end
    end

    assign SC_LEVELTIMER_TICK_Out     = tick_reg;
    assign SC_LEVELTIMER_LEVEL_Out    = level_reg;
    assign SC_LEVELTIMER_SPEEDSEL_Out = band_of(level_reg);
    assign SC_LEVELTIMER_RUNNING_Out  = (state_reg == ST_RUN);
    assign SC_LEVELTIMER_DONE_Out     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sc_level_timer.sv
// Bench for sc_level_timer: directed scenarios plus random stimulus, all checked each
// cycle against an elapsed-cycle model of the pacing rules.
module tb_sc_level_timer;

    localparam int P_SLOW = 5, P_MED = 4, P_FAST = 3;
    localparam int L_SLOW = 1, L_MED = 2, L_LAST = 3, TPL = 2;

    logic       clk;
    logic       rst_n;
    logic       start_n;
    logic       pause;
    logic       clear;
    logic       tick;
    logic [7:0] level;
    logic [1:0] speedsel;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 started (running or paused), 2 finished.
    int m_mode, m_level, m_ticks, m_elapsed;
    bit m_paused, m_tick;

    sc_level_timer #(
        .CNT_WIDTH(25), .LV_WIDTH(8),
        .PERIOD_SLOW(P_SLOW), .PERIOD_MED(P_MED), .PERIOD_FAST(P_FAST),
        .LV_SLOW_MAX(L_SLOW), .LV_MED_MAX(L_MED), .LV_MAX(L_LAST),
        .TICKS_PER_LEVEL(TPL)
    ) dut (
        .SC_LEVELTIMER_CLOCK_50    (clk),
        .SC_LEVELTIMER_RESET_InLow (rst_n),
        .SC_LEVELTIMER_START_InLow (start_n),
        .SC_LEVELTIMER_PAUSE_InHigh(pause),
        .SC_LEVELTIMER_CLEAR_InHigh(clear),
        .SC_LEVELTIMER_TICK_Out    (tick),
        .SC_LEVELTIMER_LEVEL_Out   (level),
        .SC_LEVELTIMER_SPEEDSEL_Out(speedsel),
        .SC_LEVELTIMER_RUNNING_Out (running),
        .SC_LEVELTIMER_DONE_Out    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period(input int l);
        return (l <= L_SLOW) ? P_SLOW : (l <= L_MED) ? P_MED : P_FAST;
    endfunction

    function automatic int band(input int l);
        return (l <= L_SLOW) ? 0 : (l <= L_MED) ? 1 : 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_level = 0; m_ticks = 0; m_elapsed = 0;
        m_paused = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit s_n, input bit p, input bit c);
        m_tick = 0;
        if (c) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (!s_n) begin
                m_mode = 1; m_paused = 0; m_elapsed = 0;
            end
        end else if (m_mode == 1) begin
            if (p) begin
                m_paused = 1;
            end else begin
                m_paused = 0;
                m_elapsed++;
                if (m_elapsed == period(m_level)) begin
                    m_tick = 1;
                    m_elapsed = 0;
                    m_ticks++;
                    if (m_ticks == TPL) begin
                        m_ticks = 0;
                        if (m_level < L_LAST) m_level++;
                        else m_mode = 2;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("tick", tick, m_tick);
        chk("level", level, m_level);
        chk("speedsel", speedsel, band(m_level));
        chk("running", running, (m_mode == 1 && !m_paused) ? 1 : 0);
        chk("done", done, (m_mode == 2) ? 1 : 0);
    endtask

    // Called at a falling edge; covers exactly one rising edge and returns at the next falling edge.
    task automatic cycle(input bit s_n, input bit p, input bit c);
        start_n = s_n; pause = p; clear = c;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(s_n, p, c);
        @(negedge clk);
        compare_all();
        $display("cyc t=%0t start_n=%0b pause=%0b clear=%0b -> tick=%0b level=%0d sp=%0d run=%0b done=%0b",
                 $time, s_n, p, c, tick, level, speedsel, running, done);
    endtask

    // Called at a falling edge; drops reset mid-low-phase and checks outputs before the next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_before_edge", clk, 0);
        chk("async_tick", tick, 0);
        chk("async_level", level, 0);
        chk("async_running", running, 0);
        chk("async_done", done, 0);
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    int tick_at[$];
    int lvl_at[$];
    int sp_at[$];
    int exp_tick_at[8] = '{5, 10, 15, 20, 24, 28, 31, 34};
    int exp_lvl_at[8]  = '{0, 1, 1, 2, 2, 3, 3, 3};
    int exp_sp_at[8]   = '{0, 0, 0, 1, 1, 2, 2, 2};

    initial begin
        int n;
        int k;
        rst_n = 1'b0; start_n = 1'b1; pause = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();

        // Reset held for three cycles, then idle with no start
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        chk("idle_level", level, 0);

        // Start, pace through all levels to DONE, then verify silence
        cycle(0, 0, 0);
        chk("running_after_start", running, 1);
        for (int i = 1; i <= 60; i++) begin
            cycle(1, 0, 0);
            if (tick) begin
                tick_at.push_back(i);
                lvl_at.push_back(int'(level));
                sp_at.push_back(int'(speedsel));
            end
        end
        chk("tick_count", tick_at.size(), 8);
        for (int i = 0; i < 8 && i < tick_at.size(); i++) begin
            chk("tick_edge", tick_at[i], exp_tick_at[i]);
            chk("tick_level", lvl_at[i], exp_lvl_at[i]);
            chk("tick_speed", sp_at[i], exp_sp_at[i]);
        end
        chk("done_final", done, 1);
        chk("running_final", running, 0);

        // Pause on the terminal-count edge
        cycle(1, 0, 1);
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(1, 1, 0);
            n += int'(tick);
        end
        chk("pause_no_tick", n, 0);
        cycle(1, 0, 0);
        chk("tick_after_resume", tick, 1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1, 0, 0);
            if (tick) begin k = i; break; end
        end
        chk("spacing_after_resume", k, 5);

        // Run to level 2, then collide clear with start
        for (int i = 0; i < 40 && m_level < 2; i++) cycle(1, 0, 0);
        chk("reached_level2", level, 2);
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        chk("clear_level", level, 0);
        chk("clear_tick", tick, 0);
        chk("clear_running", running, 0);
        cycle(0, 0, 0);
        chk("restart_running", running, 1);

        // Async reset with two edges left in the period
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        async_reset();

        // Restart after reset keeps the slow spacing
        cycle(0, 0, 0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1, 0, 0);
            if (tick) begin k = i; break; end
        end
        chk("first_tick_after_reset", k, 5);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            bit p, c, s;
            if ($urandom_range(0, 799) == 0) begin
                async_reset();
            end else begin
                p = ($urandom_range(0, 5) == 0);
                c = ($urandom_range(0, 79) == 0);
                s = !(!p && $urandom_range(0, 5) == 0);
                cycle(s, p, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
